// File: rtl/seven_segment_scan.sv
// Multiplexed seven-segment scanner: time-slotted digit drive with PWM
// brightness, blink, leading-zero suppression and frame-aligned input snapshots.
module seven_segment_scan #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV_WIDTH    = 18,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_WIDTH  = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] number_display,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
    output logic [7:0]              out_cathode,
    output logic [NUM_DIGITS-1:0]   out_anode,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_WIDTH-1:0] BLANK_END = DIV_WIDTH'(BLANK_CYCLES);

    logic [DIV_WIDTH-1:0]    slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [BLINK_WIDTH-1:0]  blink_cnt;

    logic [4*NUM_DIGITS-1:0] num_s;
    logic [NUM_DIGITS-1:0]   dp_s;
    logic [NUM_DIGITS-1:0]   en_s;
    logic [NUM_DIGITS-1:0]   bm_s;
    logic                    lz_s;
    logic [3:0]              bright_s;

    logic                    slot_wrap;
    logic                    frame_edge;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_bm;
    logic                    cur_lz;
    logic                    lit;
    logic [7:0]              seg;
    logic [7:0]              cathode_next;
    logic [NUM_DIGITS-1:0]   anode_next;

    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'h03;
            4'h1:    code = 8'h9F;
            4'h2:    code = 8'h25;
            4'h3:    code = 8'h0D;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h49;
            4'h6:    code = 8'h41;
            4'h7:    code = 8'h1F;
            4'h8:    code = 8'h01;
            4'h9:    code = 8'h09;
            4'hA:    code = 8'h11;
            4'hB:    code = 8'hC1;
            4'hC:    code = 8'h63;
            4'hD:    code = 8'h85;
            4'hE:    code = 8'h61;
            4'hF:    code = 8'h71;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    assign slot_wrap  = &slot_cnt;
    assign frame_edge = (slot_cnt == '0) && (digit_idx == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt    <= '0;
            digit_idx   <= '0;
            blink_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            slot_cnt    <= slot_cnt + 1'b1;
            blink_cnt   <= blink_cnt + 1'b1;
            frame_start <= frame_edge;
            if (slot_wrap) begin
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Inputs are only sampled once per frame so a frame never mixes values.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_s    <= '0;
            dp_s     <= '0;
            en_s     <= '0;
            bm_s     <= '0;
            lz_s     <= 1'b0;
            bright_s <= '0;
        end else if (frame_edge) begin
            num_s    <= number_display;
            dp_s     <= dp_in;
            en_s     <= digit_en;
            bm_s     <= blink_mask;
            lz_s     <= lz_blank;
            bright_s <= brightness;
        end
    end

    // Walk down from the top digit; a set dp breaks the run of zeros.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (num_s[4*i +: 4] == 4'h0) & ~dp_s[i];
            lz_mask[i] = lz_s & zero_run & (i != 0);
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_bm  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_nib = num_s[4*i +: 4];
                cur_dp  = dp_s[i];
                cur_en  = en_s[i];
                cur_bm  = bm_s[i];
                cur_lz  = lz_mask[i];
            end
        end
    end

    always_comb begin
        lit = cur_en
            & ~cur_lz
            & ~(cur_bm & blink_cnt[BLINK_WIDTH-1])
            & (slot_cnt >= BLANK_END)
            & (slot_cnt[3:0] <= bright_s);
        seg = seg_code(cur_nib);
        cathode_next = lit ? {seg[7:1], seg[0] & ~cur_dp} : 8'hFF;
        anode_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_next[i] = ~(lit & (digit_idx == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_anode   <= '1;
            out_cathode <= 8'hFF;
        end else begin
            out_anode   <= anode_next;
            out_cathode <= cathode_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: 4-digit and 3-digit instances checked
// cycle by cycle against a time-indexed reference model.
module tb_seven_segment_scan;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int BC    = 2;
    localparam int BW    = 8;
    localparam int SLOT  = 16;
    localparam int FRAME = ND * SLOT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] num;
    logic [3:0]  dp, en, bm, br;
    logic        lz;
    logic [7:0]  ca;
    logic [3:0]  an;
    logic        fs;

    logic        reset3;
    logic [11:0] num3 = 12'h5A7;
    logic [2:0]  dp3 = 3'b000;
    logic [2:0]  en3 = 3'b111;
    logic [2:0]  bm3 = 3'b000;
    logic        lz3 = 1'b0;
    logic [3:0]  br3 = 4'hF;
    logic [7:0]  ca3;
    logic [2:0]  an3;
    logic        fs3;

    seven_segment_scan #(
        .NUM_DIGITS(ND), .DIV_WIDTH(DW),
        .BLANK_CYCLES(BC), .BLINK_WIDTH(BW)
    ) dut (
        .clk(clk), .reset(reset),
        .number_display(num), .dp_in(dp),
        .digit_en(en), .blink_mask(bm),
        .lz_blank(lz), .brightness(br),
        .out_cathode(ca), .out_anode(an),
        .frame_start(fs)
    );

    seven_segment_scan #(
        .NUM_DIGITS(3), .DIV_WIDTH(DW),
        .BLANK_CYCLES(BC), .BLINK_WIDTH(BW)
    ) dut3 (
        .clk(clk), .reset(reset3),
        .number_display(num3), .dp_in(dp3),
        .digit_en(en3), .blink_mask(bm3),
        .lz_blank(lz3), .brightness(br3),
        .out_cathode(ca3), .out_anode(an3),
        .frame_start(fs3)
    );

    logic [7:0] seg_tab [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    int checks = 0;
    int fails  = 0;
    int t  = 0;
    int t3 = 0;

    logic [15:0] m_num;
    logic [3:0]  m_dp, m_en, m_bm, m_br;
    logic        m_lz;

    logic [3:0] exp_an;
    logic [7:0] exp_ca;
    logic       exp_fs;
    logic [2:0] exp_an3;
    logic [7:0] exp_ca3;
    logic       exp_fs3;

    logic [3:0] prev_an;
    logic [7:0] prev_ca;
    bit         have_prev = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Expected outputs of the next cycle, derived from elapsed time since
    // reset release and the inputs held at the last frame boundary.
    task automatic predict();
        int slot, idx, blink;
        bit lit, lzb;
        logic [3:0] nib;
        logic [7:0] code;
        if (reset) begin
            exp_an = 4'hF;
            exp_ca = 8'hFF;
            exp_fs = 1'b0;
            m_num = '0; m_dp = '0; m_en = '0;
            m_bm = '0; m_br = '0; m_lz = 1'b0;
            t = 0;
        end else begin
            slot  = t % SLOT;
            idx   = (t / SLOT) % ND;
            blink = t % 256;
            nib   = m_num[4*idx +: 4];
            lzb   = m_lz && idx > 0
                 && ((m_num >> (4*idx)) == 16'h0)
                 && ((m_dp >> idx) == 4'h0);
            lit   = m_en[idx] && !lzb
                 && !(m_bm[idx] && blink >= 128)
                 && slot >= BC && slot <= int'(m_br);
            code  = seg_tab[nib];
            if (m_dp[idx]) code[0] = 1'b0;
            exp_an = lit ? ~(4'b0001 << idx) : 4'hF;
            exp_ca = lit ? code : 8'hFF;
            exp_fs = (t % FRAME == 0);
            if (t % FRAME == 0) begin
                m_num = num; m_dp = dp; m_en = en;
                m_bm = bm; m_br = br; m_lz = lz;
            end
            t++;
        end
        if (reset3) begin
            exp_an3 = 3'h7;
            exp_ca3 = 8'hFF;
            exp_fs3 = 1'b0;
            t3 = 0;
        end else begin
            slot = t3 % SLOT;
            idx  = (t3 / SLOT) % 3;
            lit  = t3 >= 1 && slot >= BC;
            exp_an3 = lit ? ~(3'b001 << idx) : 3'h7;
            exp_ca3 = lit ? seg_tab[num3[4*idx +: 4]] : 8'hFF;
            exp_fs3 = (t3 % 48 == 0);
            t3++;
        end
    endtask

    task automatic tick();
        predict();
        @(negedge clk);
        chk("anode", 32'(an), 32'(exp_an));
        chk("cathode", 32'(ca), 32'(exp_ca));
        chk("frame_start", 32'(fs), 32'(exp_fs));
        chk("anode3", 32'(an3), 32'(exp_an3));
        chk("cathode3", 32'(ca3), 32'(exp_ca3));
        chk("frame_start3", 32'(fs3), 32'(exp_fs3));
        chk("anode_onehot", 32'($countones(~an) <= 1), 32'd1);
        chk("anode3_onehot", 32'($countones(~an3) <= 1), 32'd1);
        if (have_prev) begin
            chk("glitch_free",
                32'((ca == prev_ca) || (an != prev_an)
                    || (an == 4'hF) || (prev_an == 4'hF)),
                32'd1);
        end
        prev_an = an;
        prev_ca = ca;
        have_prev = 1;
    endtask

    initial begin
        reset = 1'b1; reset3 = 1'b1;
        num = '0; dp = '0; en = '0; bm = '0; br = '0; lz = 1'b0;
        repeat (3) tick();

        num = 16'h12AF; en = 4'hF; br = 4'hF;
        reset = 1'b0; reset3 = 1'b0;
        repeat (2 * FRAME + 5) tick();

        num = 16'h0030; lz = 1'b1;
        repeat (2 * FRAME) tick();
        dp = 4'b0100;
        repeat (2 * FRAME) tick();

        dp = '0; lz = 1'b0; num = 16'h4567;
        br = 4'd0;
        repeat (2 * FRAME) tick();
        br = 4'd7;
        repeat (2 * FRAME) tick();

        br = 4'hF;
        repeat (20) tick();
        num = 16'h9876;
        repeat (FRAME + 10) tick();

        while (t3 % SLOT != 7) tick();
        reset3 = 1'b1;
        tick();
        reset3 = 1'b0;
        repeat (3 * 48) tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        bm = 4'b0001;
        repeat (600) tick();

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 40) == 0) begin
                num = 16'($urandom) >> (4 * $urandom_range(0, 4));
                dp  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                en  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
                bm  = 4'($urandom);
                lz  = 1'($urandom);
                br  = 4'($urandom);
            end
            reset  = ($urandom_range(0, 400) == 0);
            reset3 = ($urandom_range(0, 300) == 0);
            tick();
        end
        reset = 1'b0; reset3 = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
